// File: rtl/writeback_regfile.sv
// Writeback stage: selects one of four results, commits it to the register file,
// updates the N/Z/P condition code and returns two registered source operands.
module writeback_regfile #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_writeback,
  input  logic [1:0]        W_Control,
  input  logic [DATA_W-1:0] aluout,
  input  logic [DATA_W-1:0] memout,
  input  logic [DATA_W-1:0] pcout,
  input  logic [DATA_W-1:0] npc,
  input  logic [ADDR_W-1:0] dr,
  input  logic [ADDR_W-1:0] sr1,
  input  logic [ADDR_W-1:0] sr2,
  output logic [2:0]        psr,
  output logic [DATA_W-1:0] vsr1,
  output logic [DATA_W-1:0] vsr2
);

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_MEM = 2'd1,
    SRC_PC  = 2'd2,
    SRC_NPC = 2'd3
  } wb_src_e;

  logic [DATA_W-1:0] rf [NUM_REGS];
  logic [DATA_W-1:0] wb_data;
  logic [2:0]        psr_next;
  logic              psr_update;
  logic              fwd1;
  logic              fwd2;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wb_data = aluout;
    unique case (wb_src_e'(W_Control))
      SRC_ALU: wb_data = aluout;
      SRC_MEM: wb_data = memout;
      SRC_PC:  wb_data = pcout;
      SRC_NPC: wb_data = npc;
      default: wb_data = aluout;
    endcase
  end

  // Link writes (npc) must not disturb the condition code.
  always_comb begin
    psr_update = enable_writeback && (wb_src_e'(W_Control) != SRC_NPC);
    psr_next   = 3'b001;
    if (wb_data[DATA_W-1])
      psr_next = 3'b100;
    else if (wb_data == '0)
      psr_next = 3'b010;
  end

  assign fwd1 = BYPASS && enable_writeback && (dr == sr1);
  assign fwd2 = BYPASS && enable_writeback && (dr == sr2);

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  // NOTE: the register file is cleared on reset because software may read it before writing it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        rf[i] <= '0;
    end else if (enable_writeback) begin
      rf[dr] <= wb_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      psr  <= 3'b000;
      vsr1 <= '0;
      vsr2 <= '0;
    end else begin
      if (psr_update)
        psr <= psr_next;
      vsr1 <= fwd1 ? wb_data : rf[sr1];
      vsr2 <= fwd2 ? wb_data : rf[sr2];
    end
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench: a BYPASS=1 and a BYPASS=0 16-bit instance share stimulus,
// a 32-bit/16-register instance checks the wide configuration.
module tb_writeback_regfile;

  logic        clock;
  logic        reset;

  logic        en;
  logic [1:0]  wctl;
  logic [15:0] alu, mem, pc, np;
  logic [2:0]  dr, sr1, sr2;
  logic [2:0]  psr_b, psr_n;
  logic [15:0] vsr1_b, vsr2_b, vsr1_n, vsr2_n;

  logic        w_en;
  logic [1:0]  w_wctl;
  logic [31:0] w_alu, w_mem, w_pc, w_np;
  logic [3:0]  w_dr, w_sr1, w_sr2;
  logic [2:0]  w_psr;
  logic [31:0] w_vsr1, w_vsr2;

  int checks;
  int errors;

  writeback_regfile #(.DATA_W(16), .NUM_REGS(8), .BYPASS(1'b1)) u_byp (
    .clock(clock), .reset(reset), .enable_writeback(en), .W_Control(wctl),
    .aluout(alu), .memout(mem), .pcout(pc), .npc(np),
    .dr(dr), .sr1(sr1), .sr2(sr2), .psr(psr_b), .vsr1(vsr1_b), .vsr2(vsr2_b)
  );

  writeback_regfile #(.DATA_W(16), .NUM_REGS(8), .BYPASS(1'b0)) u_nobyp (
    .clock(clock), .reset(reset), .enable_writeback(en), .W_Control(wctl),
    .aluout(alu), .memout(mem), .pcout(pc), .npc(np),
    .dr(dr), .sr1(sr1), .sr2(sr2), .psr(psr_n), .vsr1(vsr1_n), .vsr2(vsr2_n)
  );

  writeback_regfile #(.DATA_W(32), .NUM_REGS(16), .BYPASS(1'b1)) u_wide (
    .clock(clock), .reset(reset), .enable_writeback(w_en), .W_Control(w_wctl),
    .aluout(w_alu), .memout(w_mem), .pcout(w_pc), .npc(w_np),
    .dr(w_dr), .sr1(w_sr1), .sr2(w_sr2), .psr(w_psr), .vsr1(w_vsr1), .vsr2(w_vsr2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Selected source carries val; the others carry ~val so a wrong mux select shows up.
  task automatic wr16(input logic [1:0] sel, input logic [15:0] val, input logic [2:0] d);
    en   = 1'b1;
    wctl = sel;
    dr   = d;
    alu  = (sel == 2'd0) ? val : ~val;
    mem  = (sel == 2'd1) ? val : ~val;
    pc   = (sel == 2'd2) ? val : ~val;
    np   = (sel == 2'd3) ? val : ~val;
    tick();
    en   = 1'b0;
  endtask

  task automatic wr32(input logic [1:0] sel, input logic [31:0] val, input logic [3:0] d);
    w_en   = 1'b1;
    w_wctl = sel;
    w_dr   = d;
    w_alu  = (sel == 2'd0) ? val : ~val;
    w_mem  = (sel == 2'd1) ? val : ~val;
    w_pc   = (sel == 2'd2) ? val : ~val;
    w_np   = (sel == 2'd3) ? val : ~val;
    tick();
    w_en   = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    en = 0; wctl = 0; alu = 0; mem = 0; pc = 0; np = 0; dr = 0; sr1 = 0; sr2 = 0;
    w_en = 0; w_wctl = 0; w_alu = 0; w_mem = 0; w_pc = 0; w_np = 0;
    w_dr = 0; w_sr1 = 0; w_sr2 = 0;
    reset = 1'b1;
    #3 reset = 1'b0;
    tick();
    tick();
    check("reset_psr", 64'(psr_b), 64'h0);
    check("reset_vsr1", 64'(vsr1_b), 64'h0);
    check("reset_vsr2", 64'(vsr2_b), 64'h0);
    check("reset_wide_psr", 64'(w_psr), 64'h0);
    reset = 1'b1;

    // Mid-stream reset clears a written register and the outputs immediately.
    wr16(2'd0, 16'h1234, 3'd3);
    check("wr_r3_psr", 64'(psr_b), 64'h1);
    sr1 = 3'd3; sr2 = 3'd3;
    tick();
    check("rd_r3", 64'(vsr1_b), 64'h1234);
    reset = 1'b0;
    #1;
    check("async_rst_psr", 64'(psr_b), 64'h0);
    check("async_rst_vsr1", 64'(vsr1_b), 64'h0);
    check("async_rst_vsr2", 64'(vsr2_b), 64'h0);
    wr16(2'd0, 16'h4321, 3'd3);
    check("rst_write_psr", 64'(psr_b), 64'h0);
    reset = 1'b1;
    tick();
    check("post_rst_r3", 64'(vsr1_b), 64'h0000);

    // Condition code encoding per source.
    wr16(2'd0, 16'h8000, 3'd1);
    check("psr_neg", 64'(psr_b), 64'h4);
    wr16(2'd1, 16'h0000, 3'd2);
    check("psr_zero", 64'(psr_b), 64'h2);
    wr16(2'd2, 16'h0005, 3'd4);
    check("psr_pos", 64'(psr_b), 64'h1);
    wr16(2'd3, 16'hFFFF, 3'd7);
    check("psr_npc_hold", 64'(psr_b), 64'h1);
    sr1 = 3'd7; sr2 = 3'd1;
    tick();
    check("rd_r7", 64'(vsr1_b), 64'hFFFF);
    check("rd_r1", 64'(vsr2_b), 64'h8000);
    sr1 = 3'd2; sr2 = 3'd4;
    tick();
    check("rd_r2", 64'(vsr1_b), 64'h0000);
    check("rd_r4", 64'(vsr2_b), 64'h0005);

    // Same-cycle read/write of r5, with and without bypass.
    sr1 = 3'd0; sr2 = 3'd0;
    wr16(2'd0, 16'h0001, 3'd5);
    sr1 = 3'd5;
    wr16(2'd0, 16'hBEEF, 3'd5);
    check("fwd_byp", 64'(vsr1_b), 64'hBEEF);
    check("fwd_nobyp_old", 64'(vsr1_n), 64'h0001);
    tick();
    check("fwd_nobyp_new", 64'(vsr1_n), 64'hBEEF);
    check("fwd_byp_hold", 64'(vsr1_b), 64'hBEEF);

    // Dual read and aliasing; last qualifying write leaves psr=010.
    wr16(2'd0, 16'h00AA, 3'd2);
    wr16(2'd0, 16'h7FFF, 3'd6);
    wr16(2'd1, 16'h0000, 3'd0);
    sr1 = 3'd2; sr2 = 3'd2;
    tick();
    check("alias_vsr1", 64'(vsr1_b), 64'h00AA);
    check("alias_vsr2", 64'(vsr2_b), 64'h00AA);
    sr2 = 3'd6;
    tick();
    check("dual_vsr1", 64'(vsr1_b), 64'h00AA);
    check("dual_vsr2", 64'(vsr2_b), 64'h7FFF);
    check("dual_psr", 64'(psr_b), 64'h2);

    // Disabled write: no commit, no psr change, no forwarding.
    en = 1'b0; wctl = 2'd0; dr = 3'd0; alu = 16'h1111; sr1 = 3'd0;
    tick();
    check("dis_fwd", 64'(vsr1_b), 64'h0000);
    tick();
    check("dis_r0", 64'(vsr1_b), 64'h0000);
    check("dis_psr", 64'(psr_b), 64'h2);

    // Wide configuration.
    wr32(2'd0, 32'h8000_0000, 4'd15);
    check("wide_psr_neg", 64'(w_psr), 64'h4);
    w_sr1 = 4'd15;
    tick();
    check("wide_r15", 64'(w_vsr1), 64'h8000_0000);
    wr32(2'd1, 32'h0000_0001, 4'd0);
    check("wide_psr_pos", 64'(w_psr), 64'h1);
    for (int i = 0; i < 16; i++)
      wr32(2'(i % 3), 32'hA500_0000 | (32'(i) * 32'h0001_0101), 4'(i));
    for (int i = 0; i < 16; i++) begin
      w_sr1 = 4'(i);
      w_sr2 = 4'(15 - i);
      tick();
      check($sformatf("wide_rt1_r%0d", i), 64'(w_vsr1), 64'(32'hA500_0000 | (32'(i) * 32'h0001_0101)));
      check($sformatf("wide_rt2_r%0d", 15 - i), 64'(w_vsr2),
            64'(32'hA500_0000 | (32'(15 - i) * 32'h0001_0101)));
    end

    $display("test done: total=%0d bad=%0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_regfile.md
# writeback_regfile

Parametrised writeback stage with register file for the LC3-class pipeline, succeeding the fixed 16-bit/8-register writeback.

- Selects the writeback result from four sources and commits it to a NUM_REGS × DATA_W register file.
- Derives the N/Z/P condition code into psr.
- Returns two registered source operands, vsr1 and vsr2, with optional same-cycle write forwarding.
- Sits between execute/memaccess and decode; its psr/vsr1/vsr2 outputs drive the writeback_out agent bus.

## Interface

Parameters:
- DATA_W, 16, datapath width; legal range 4..64.
- NUM_REGS, 8, register count; must be a power of two, 2..64.
- ADDR_W, $clog2(NUM_REGS), register index width. Derived; do not override.
- BYPASS, 1, 1 = a read of the register being written returns the new value; 0 = returns the old value.

Ports:
- clock, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset.
- enable_writeback, input, 1: commit the selected result this cycle.
- W_Control, input, 2: source select. 0 = aluout, 1 = memout, 2 = pcout, 3 = npc.
- aluout, input, DATA_W: ALU result.
- memout, input, DATA_W: load data.
- pcout, input, DATA_W: computed address (LEA).
- npc, input, DATA_W: link address.
- dr, input, ADDR_W: destination register index.
- sr1, input, ADDR_W: source 1 index.
- sr2, input, ADDR_W: source 2 index.
- psr, output, 3: condition code {N, Z, P}.
- vsr1, output, DATA_W: registered value of sr1.
- vsr2, output, DATA_W: registered value of sr2.

## Operation

- wb_data = mux(W_Control: aluout, memout, pcout, npc). This mux is combinational.
- Register write, at a rising edge with enable_writeback=1: rf[dr] <= wb_data.
- PSR update, at the same edge, if enable_writeback=1 and W_Control != 3:
  - wb_data[DATA_W-1]=1 → psr <= 3'b100.
  - wb_data == 0 → psr <= 3'b010.
  - otherwise → psr <= 3'b001.
- npc writes (link, W_Control=3) leave psr unchanged.
- Reads happen at every rising edge, with no enable:
  - vsr1 <= fwd1 ? wb_data : rf[sr1], where fwd1 = BYPASS && enable_writeback && (dr == sr1).
  - vsr2 is computed the same way from sr2.
- sr1 == sr2: both outputs carry the same value, and forwarding applies independently to each.
- All register indices 0..NUM_REGS-1 are writable; there is no hard-wired zero register.
- Register-file arithmetic has no overflow or saturation. Values are stored verbatim, truncated to DATA_W by port width only.
- Reset asserted (reset=0), at any time:
  - all rf entries, vsr1, vsr2 → 0.
  - psr → 3'b000.
  - The reset is effective immediately, independent of clock.
  - A write in progress at the clock edge coincident with reset assertion is discarded.
- Reset release (reset 0→1): the first edge with reset=1 behaves as a normal cycle. No writes are accepted while reset=0.
- There is no handshake and no back-pressure. The block accepts one write and two reads every cycle.

## Timing

- Write latency:
  - rf[dr] is updated at edge T, where enable_writeback=1 is sampled.
  - A read of dr issued at T+1 returns the new value at T+1.
  - With BYPASS=1, a read issued at T itself also returns the new value, visible after edge T.
- Read latency: one cycle. sr1/sr2 are sampled at edge T, and vsr1/vsr2 are valid after T until the next edge.
- psr latency: one cycle after the qualifying write edge. It holds its value until the next qualifying write or reset.
- BYPASS=0 with a read and write of the same register at edge T: vsr returns the pre-write value; the new value appears on a read at T+1.
- All outputs are registered. There are no combinational input-to-output paths.

## Test plan

- Reset: drive reset=0 mid-stream after rf[3]=16'h1234 is written → psr=000, vsr1=vsr2=0 immediately. After release, reading sr1=3 returns 16'h0000.
- PSR encoding: write aluout=16'h8000 to r1 → psr=100. Then memout=0 to r2 → psr=010. Then pcout=16'h0005 to r4 → psr=001. Then npc=16'hFFFF to r7 → psr stays 001, and r7 reads 16'hFFFF.
- Forwarding: BYPASS=1, dr=sr1=5, aluout=16'hBEEF, old rf[5]=16'h0001 → vsr1=16'hBEEF one cycle later. With BYPASS=0, the same stimulus → vsr1=16'h0001, then 16'hBEEF on the next cycle.
- Dual read and aliasing: rf[2]=16'h00AA, sr1=sr2=2, no write → vsr1=vsr2=16'h00AA. Then sr1=2, sr2=6 with rf[6]=16'h7FFF → vsr2=16'h7FFF and psr unchanged.
- Write disabled: enable_writeback=0, dr=0, aluout=16'h1111 → rf[0] is unchanged and psr is unchanged.
- Parametrisation: DATA_W=32, NUM_REGS=16. Write 32'h8000_0000 to r15 → psr=100 and r15 reads back 32'h8000_0000. Write 32'h0000_0001 to r0 → psr=001, and every register round-trips independently.
